rs_station_param: RTL
=====================

Name: rs_station_param

Overview:
- Parametrised Tomasulo reservation station: the next generation of the add/mul station append logic.
- Holds up to DEPTH instructions for one functional-unit class.
- Snoops the common data bus (CDB) for pending source tags and issues ready entries to the FU under a valid/ready handshake.
- Sits between dispatch (rename/ROB allocate) and one FU; one instance per FU class (add/branch/ldst, mul/div).

Parameters:
- DEPTH, 4, number of entries (2..16)
- DATA_W, 16, operand value width
- ROB_W, 3, ROB index / CDB tag width
- OP_W, 4, function code width

Ports:
- clk2  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all entries (mispredict)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept this cycle
- disp_op  in  OP_W  function code
- disp_rob  in  ROB_W  destination ROB index
- disp_j_rdy  in  1  1 = disp_vj holds a value; 0 = waiting on disp_qj
- disp_vj  in  DATA_W  source j value
- disp_qj  in  ROB_W  source j producer tag
- disp_k_rdy, disp_vk, disp_qk  in  1/DATA_W/ROB_W  same fields for source k
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  ROB_W  producing ROB index
- cdb_data  in  DATA_W  broadcast value
- iss_valid  out  1  an entry is ready to issue
- iss_ready  in  1  FU accepts
- iss_op  out  OP_W  issued function code
- iss_vj, iss_vk  out  DATA_W  issued operands
- iss_rob  out  ROB_W  issued ROB index
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Clocking/reset: one clock, clk2; reset rst_n is asynchronous, active-low.
- Reset: all busy bits 0, count=0, disp_ready=1, iss_valid=0. iss_op/iss_vj/iss_vk/iss_rob are 0 whenever iss_valid=0.
- Entry fields: busy, op, rob, vj, qj, j_rdy, vk, qk, k_rdy.
- disp_ready = (count < DEPTH) && !flush. It is combinational from state and does not anticipate a same-cycle issue.
- Dispatch fires on disp_valid && disp_ready. The entry is written into the lowest-index free entry at the next edge.
- Wakeup: at each edge, every busy entry with j_rdy=0 and qj==cdb_tag while cdb_valid loads vj=cdb_data and sets j_rdy=1. Source k is handled the same way. Both operands may wake in the same cycle.
- Dispatch-cycle capture is mandatory: if a dispatched source is not ready and its q equals cdb_tag with cdb_valid, the entry is written with that source ready and the CDB value.
- Issue eligibility: busy && j_rdy && k_rdy, taken from registered state. Selection is the lowest-index eligible entry.
- iss_* is driven combinationally from the selected entry.
- On iss_valid && iss_ready, the entry's busy bit clears at the next edge.
- Issue is held stable while iss_ready=0: the selected entry does not change unless a lower-index entry becomes eligible. The FU must therefore sample only on handshake.
- Simultaneous dispatch and issue: both take effect and count is unchanged. Dispatch may reuse the entry freed in the same cycle only from the next cycle.
- count updates as count + dispatch_fire - issue_fire, saturating at 0..DEPTH by construction.
- flush takes priority over dispatch, issue and wakeup: all busy bits clear and count=0 at the next edge. During the flush cycle iss_valid=0 and disp_ready=0.
- Reset asserted mid-operation: state clears immediately, with no partial-entry retention.
- Tag match on a non-busy entry is ignored.

Optional Feature:
- Macro: RS_WAKEUP_BYPASS_EN.
- Defined: an entry whose last missing operand matches the current CDB broadcast is issue-eligible in that same cycle. The matching iss_vj/iss_vk is muxed from cdb_data, removing one cycle of wakeup-to-issue latency.
- Undefined: eligibility uses registered ready bits only, so issue comes at the earliest one cycle after the broadcast.

Decomposition:
- Shared package rs_pkg holds:
  - Op-code constants: ADD 0000, SUB 0001, MUL 0010, DIV 0011, LD 0100, ST 0101, BEQ 0110, BNE 0111.
  - Entry record typedef.
  - Default widths.
- Sub-module rs_pick_first(N): lowest-index-set-bit priority encoder with a found flag. It is instantiated twice, once for free-slot selection and once for issue selection.

Test Plan:
- Dispatch ADD rob=2 with vj=5 and vk=7 both ready, iss_ready=1 -> iss_valid next cycle with iss_vj=5, iss_vk=7, iss_rob=2; count returns 1->0.
- Dispatch MUL rob=3 waiting on qj=1, then CDB tag=1 data=0x00AA two cycles later -> issue with iss_vj=0x00AA one cycle after the broadcast without the macro, same cycle with RS_WAKEUP_BYPASS_EN.
- Dispatch with qk=4 while the same cycle carries CDB tag=4 data=9 -> entry captures vk=9 and issues next cycle.
- Fill DEPTH=4 entries with iss_ready=0 -> disp_ready=0 and count=4; a 5th disp_valid is not accepted. Raise iss_ready -> entry 0 issues first, and disp_ready=1 the next cycle.
- Three entries stalled waiting on tag 6, pulse flush -> count=0, iss_valid=0; a later CDB tag=6 produces no issue.
- Assert rst_n=0 asynchronously mid-operation with 2 entries busy -> count=0 and iss_valid=0 before the next clk2 edge.

Source files
------------

// File: rtl/rs_pkg.sv
// ============================================================================
// Module : rs_pkg
// Brief  : Shared op-codes, default widths and entry record for the
//          reservation-station slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rs_pkg;

    localparam int c_def_depth  = 4;
    localparam int c_def_data_w = 16;
    localparam int c_def_rob_w  = 3;
    localparam int c_def_op_w   = 4;

    localparam logic [3:0] c_op_add = 4'b0000;
    localparam logic [3:0] c_op_sub = 4'b0001;
    localparam logic [3:0] c_op_mul = 4'b0010;
    localparam logic [3:0] c_op_div = 4'b0011;
    localparam logic [3:0] c_op_ld  = 4'b0100;
    localparam logic [3:0] c_op_st  = 4'b0101;
    localparam logic [3:0] c_op_beq = 4'b0110;
    localparam logic [3:0] c_op_bne = 4'b0111;

    // Entry record at the default widths; the station re-declares it with
    // its own parameter widths.
    typedef struct packed {
        logic                    busy;
        logic [c_def_op_w-1:0]   op;
        logic [c_def_rob_w-1:0]  rob;
        logic [c_def_data_w-1:0] vj;
        logic [c_def_rob_w-1:0]  qj;
        logic                    j_rdy;
        logic [c_def_data_w-1:0] vk;
        logic [c_def_rob_w-1:0]  qk;
        logic                    k_rdy;
    } rs_entry_t;

endpackage

`default_nettype wire

// File: rtl/rs_pick_first.sv
// ============================================================================
// Module : rs_pick_first
// Brief  : Lowest-index-set-bit priority encoder with a found flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rs_pick_first #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = IW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rs_station_param.sv
// ============================================================================
// Module : rs_station_param
// Brief  : Parametrised Tomasulo reservation station with CDB snooping and
//          valid/ready issue. Optional same-cycle wakeup bypass is enabled
//          by defining RS_WAKEUP_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rs_station_param
    import rs_pkg::*;
#(
    parameter int DEPTH  = c_def_depth,
    parameter int DATA_W = c_def_data_w,
    parameter int ROB_W  = c_def_rob_w,
    parameter int OP_W   = c_def_op_w
) (
    input  logic                         clk2,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [OP_W-1:0]              disp_op,
    input  logic [ROB_W-1:0]             disp_rob,
    input  logic                         disp_j_rdy,
    input  logic [DATA_W-1:0]            disp_vj,
    input  logic [ROB_W-1:0]             disp_qj,
    input  logic                         disp_k_rdy,
    input  logic [DATA_W-1:0]            disp_vk,
    input  logic [ROB_W-1:0]             disp_qk,
    input  logic                         cdb_valid,
    input  logic [ROB_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [OP_W-1:0]              iss_op,
    output logic [DATA_W-1:0]            iss_vj,
    output logic [DATA_W-1:0]            iss_vk,
    output logic [ROB_W-1:0]             iss_rob,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] vj;
        logic [ROB_W-1:0]  qj;
        logic              j_rdy;
        logic [DATA_W-1:0] vk;
        logic [ROB_W-1:0]  qk;
        logic              k_rdy;
    } entry_t;

    entry_t          entries_q [DEPTH];
    entry_t          entries_d [DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic [DEPTH-1:0] w_free;
    logic [DEPTH-1:0] w_elig;
    logic [IW-1:0]    w_free_idx;
    logic [IW-1:0]    w_iss_idx;
    logic             w_free_found;
    logic             w_iss_found;
    logic             w_disp_fire;
    logic             w_iss_fire;
    entry_t           w_new;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            assign w_free[g] = !entries_q[g].busy;
`ifdef RS_WAKEUP_BYPASS_EN
            assign w_elig[g] = entries_q[g].busy
                && (entries_q[g].j_rdy || (cdb_valid && entries_q[g].qj == cdb_tag))
                && (entries_q[g].k_rdy || (cdb_valid && entries_q[g].qk == cdb_tag));
`else
            assign w_elig[g] = entries_q[g].busy && entries_q[g].j_rdy
                && entries_q[g].k_rdy;
`endif
        end
    endgenerate

    rs_pick_first #(.N(DEPTH), .IW(IW)) u_pick_free (
        .i_req   (w_free),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    rs_pick_first #(.N(DEPTH), .IW(IW)) u_pick_iss (
        .i_req   (w_elig),
        .o_idx   (w_iss_idx),
        .o_found (w_iss_found)
    );

    assign disp_ready  = (count_q < CW'(DEPTH)) && !flush;
    assign w_disp_fire = disp_valid && disp_ready && w_free_found;
    assign w_iss_fire  = iss_valid && iss_ready;
    assign count       = count_q;

    always_comb begin
        iss_valid = w_iss_found && !flush;
        iss_op    = '0;
        iss_vj    = '0;
        iss_vk    = '0;
        iss_rob   = '0;
        if (iss_valid) begin
            iss_op  = entries_q[w_iss_idx].op;
            iss_rob = entries_q[w_iss_idx].rob;
            iss_vj  = entries_q[w_iss_idx].vj;
            iss_vk  = entries_q[w_iss_idx].vk;
`ifdef RS_WAKEUP_BYPASS_EN
            // Eligibility guarantees a missing operand is on the CDB now.
            if (!entries_q[w_iss_idx].j_rdy) iss_vj = cdb_data;
            if (!entries_q[w_iss_idx].k_rdy) iss_vk = cdb_data;
`endif
        end
    end

    // Incoming entry, capturing any source that is broadcast this cycle.
    always_comb begin
        w_new.busy  = 1'b1;
        w_new.op    = disp_op;
        w_new.rob   = disp_rob;
        w_new.vj    = disp_vj;
        w_new.qj    = disp_qj;
        w_new.j_rdy = disp_j_rdy;
        w_new.vk    = disp_vk;
        w_new.qk    = disp_qk;
        w_new.k_rdy = disp_k_rdy;
        if (!disp_j_rdy && cdb_valid && disp_qj == cdb_tag) begin
            w_new.vj    = cdb_data;
            w_new.j_rdy = 1'b1;
        end
        if (!disp_k_rdy && cdb_valid && disp_qk == cdb_tag) begin
            w_new.vk    = cdb_data;
            w_new.k_rdy = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) entries_d[i] = entries_q[i];
        count_d = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) entries_d[i].busy = 1'b0;
            count_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_q[i].busy && cdb_valid) begin
                    if (!entries_q[i].j_rdy && entries_q[i].qj == cdb_tag) begin
                        entries_d[i].vj    = cdb_data;
                        entries_d[i].j_rdy = 1'b1;
                    end
                    if (!entries_q[i].k_rdy && entries_q[i].qk == cdb_tag) begin
                        entries_d[i].vk    = cdb_data;
                        entries_d[i].k_rdy = 1'b1;
                    end
                end
            end
            // The free slot is never the issuing one, so the two writes are disjoint.
            if (w_iss_fire)  entries_d[w_iss_idx].busy = 1'b0;
            if (w_disp_fire) entries_d[w_free_idx]     = w_new;
            count_d = count_q + CW'(w_disp_fire) - CW'(w_iss_fire);
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire
